// File: rtl/sevensegment_scan_decoder.sv
// sevensegment_scan_decoder
//
// Receive-side decoder for an 8-digit multiplexed 7-segment display. It
// watches the active-low anode and cathode scan lines and rebuilds the 5-bit
// digit code and decimal point of every digit. It also reports when all eight
// digits have been collected.
//
// Ports:
//   clk          system clock
//   reset        asynchronous reset, active-high
//   an_in[7:0]   anode lines, active-low; bit i selects digit i
//   seg_in[7:0]  cathode lines, active-low; bit 7 = dp, bits 6:0 = g..a
//   digits_out   packed 5-bit codes, digit i at [5i+4:5i]
//   dp_out       decimal points, active-high
//   digit_update one-cycle pulse when a digit is captured
//   update_idx   index of the captured digit (valid with digit_update)
//   frame_valid  one-cycle pulse when all 8 digits were seen since the last one
//   bad_anode    one-cycle pulse: a stable window had several anodes low
//   bad_pattern  one-cycle pulse: a captured segment pattern is not decodable
module sevensegment_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an_in,
  input  logic [7:0]  seg_in,
  output logic [39:0] digits_out,
  output logic [7:0]  dp_out,
  output logic        digit_update,
  output logic [2:0]  update_idx,
  output logic        frame_valid,
  output logic        bad_anode,
  output logic        bad_pattern
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [4:0]           CODE_BLANK = 5'd23;

  logic [7:0] s1_an, s1_seg, s2_an, s2_seg, s3_an, s3_seg;
  logic [CNT_WIDTH-1:0] settle_cnt;
  logic       captured;
  logic [7:0] seen_mask;

  logic       stable;
  logic       capture_cond;
  logic [3:0] zero_count;
  logic [2:0] low_idx;
  logic [7:0] next_mask;
  logic [5:0] decoded;

  // Inverse of the driver's segment table. The MSB flags an undecodable
  // pattern; such patterns store the blank code. 0x08 is shared by A and R
  // and always yields 10, so code 26 never appears.
  function automatic logic [5:0] decode_seg(input logic [6:0] pattern);
    logic [5:0] result;
    case (pattern)
      7'h40: result = {1'b0, 5'd0};
      7'h79: result = {1'b0, 5'd1};
      7'h24: result = {1'b0, 5'd2};
      7'h30: result = {1'b0, 5'd3};
      7'h19: result = {1'b0, 5'd4};
      7'h12: result = {1'b0, 5'd5};
      7'h02: result = {1'b0, 5'd6};
      7'h78: result = {1'b0, 5'd7};
      7'h00: result = {1'b0, 5'd8};
      7'h10: result = {1'b0, 5'd9};
      7'h08: result = {1'b0, 5'd10};
      7'h03: result = {1'b0, 5'd11};
      7'h46: result = {1'b0, 5'd12};
      7'h21: result = {1'b0, 5'd13};
      7'h06: result = {1'b0, 5'd14};
      7'h0E: result = {1'b0, 5'd15};
      7'h7E: result = {1'b0, 5'd16};
      7'h7D: result = {1'b0, 5'd17};
      7'h7B: result = {1'b0, 5'd18};
      7'h77: result = {1'b0, 5'd19};
      7'h6F: result = {1'b0, 5'd20};
      7'h5F: result = {1'b0, 5'd21};
      7'h3F: result = {1'b0, 5'd22};
      7'h7F: result = {1'b0, 5'd23};
      7'h09: result = {1'b0, 5'd24};
      7'h47: result = {1'b0, 5'd25};
      7'h4F: result = {1'b0, 5'd27};
      7'h2F: result = {1'b0, 5'd28};
      default: result = {1'b1, CODE_BLANK};
    endcase
    return result;
  endfunction

  // Two-flop synchronizer plus one extra stage used to detect changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_an  <= 8'hFF;
      s1_seg <= 8'hFF;
      s2_an  <= 8'hFF;
      s2_seg <= 8'hFF;
      s3_an  <= 8'hFF;
      s3_seg <= 8'hFF;
    end else begin
      s1_an  <= an_in;
      s1_seg <= seg_in;
      s2_an  <= s1_an;
      s2_seg <= s1_seg;
      s3_an  <= s2_an;
      s3_seg <= s2_seg;
    end
  end

  // Capture happens once per stable window. The window starts when s2 stops
  // changing and qualifies when the saturating counter reaches its maximum.
  // The last low anode bit is recorded. This index only matters when exactly
  // one anode is low.
  always_comb begin
    stable       = (s2_an == s3_an) && (s2_seg == s3_seg);
    capture_cond = stable && (settle_cnt == CNT_MAX) && !captured;
    zero_count   = 4'd0;
    low_idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!s2_an[i]) begin
        zero_count = zero_count + 4'd1;
        low_idx    = 3'(i);
      end
    end
    next_mask = seen_mask | (8'b1 << low_idx);
    decoded   = decode_seg(s2_seg[6:0]);
  end

  // Settle counter and the once-per-window capture flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      captured   <= 1'b0;
    end else if (!stable) begin
      settle_cnt <= '0;
      captured   <= 1'b0;
    end else begin
      if (settle_cnt != CNT_MAX) settle_cnt <= settle_cnt + 1'b1;
      if (capture_cond)          captured   <= 1'b1;
    end
  end

  // Digit storage, frame tracking and the one-cycle status pulses. A blank
  // window (all anodes high) is a legal inter-digit gap and produces nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_out   <= {8{CODE_BLANK}};
      dp_out       <= 8'h00;
      digit_update <= 1'b0;
      update_idx   <= 3'd0;
      frame_valid  <= 1'b0;
      bad_anode    <= 1'b0;
      bad_pattern  <= 1'b0;
      seen_mask    <= 8'h00;
    end else begin
      digit_update <= 1'b0;
      frame_valid  <= 1'b0;
      bad_anode    <= 1'b0;
      bad_pattern  <= 1'b0;
      if (capture_cond) begin
        if (zero_count == 4'd1) begin
          digits_out[5*int'(low_idx) +: 5] <= decoded[4:0];
          dp_out[low_idx]                  <= ~s2_seg[7];
          digit_update                     <= 1'b1;
          update_idx                       <= low_idx;
          bad_pattern                      <= decoded[5];
          if (next_mask == 8'hFF) begin
            frame_valid <= 1'b1;
            seen_mask   <= 8'h00;
          end else begin
            seen_mask <= next_mask;
          end
        end else if (zero_count > 4'd1) begin
          bad_anode <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevensegment_scan_decoder.sv
// Testbench for sevensegment_scan_decoder.
// Stimulus pushes expected events into a queue. A monitor pops one entry on
// every output pulse and compares it with the DUT outputs.
module tb_sevensegment_scan_decoder;

  localparam int SETTLE = 4;
  localparam int LONG_HOLD = SETTLE + 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an_in = 8'hFF;
  logic [7:0]  seg_in = 8'hFF;
  logic [39:0] digits_out;
  logic [7:0]  dp_out;
  logic        digit_update;
  logic [2:0]  update_idx;
  logic        frame_valid;
  logic        bad_anode;
  logic        bad_pattern;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        upd;
    logic [2:0]  idx;
    logic        bad_an;
    logic        bad_pat;
    logic        frame;
    logic [39:0] digits;
    logic [7:0]  dp;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: the digit codes, decimal points and digits seen so far.
  int         m_code[8];
  logic       m_dp[8];
  logic       m_seen[8];
  logic [7:0] last_an = 8'hFF;
  logic [7:0] last_seg = 8'hFF;

  sevensegment_scan_decoder #(.SETTLE_CYCLES(SETTLE), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .seg_in(seg_in),
    .digits_out(digits_out), .dp_out(dp_out), .digit_update(digit_update),
    .update_idx(update_idx), .frame_valid(frame_valid),
    .bad_anode(bad_anode), .bad_pattern(bad_pattern)
  );

  always #5 clk = ~clk;

  // This table maps each code to the pattern the driver would emit. Code 26 is
  // the R pattern, which is the same pattern as A.
  function automatic logic [6:0] pat_of(input int code);
    case (code)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
     12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
     16: return 7'h7E; 17: return 7'h7D; 18: return 7'h7B; 19: return 7'h77;
     20: return 7'h6F; 21: return 7'h5F; 22: return 7'h3F; 23: return 7'h7F;
     24: return 7'h09; 25: return 7'h47; 26: return 7'h08; 27: return 7'h4F;
     default: return 7'h2F;
    endcase
  endfunction

  // Find the lowest code that produces this pattern. Return -1 if no code
  // produces it.
  function automatic int ref_decode(input logic [6:0] p);
    for (int c = 0; c <= 28; c++)
      if (pat_of(c) == p) return c;
    return -1;
  endfunction

  function automatic logic [39:0] model_digits();
    logic [39:0] r;
    for (int i = 0; i < 8; i++) r[5*i +: 5] = 5'(m_code[i]);
    return r;
  endfunction

  function automatic logic [7:0] model_dp();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_dp[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_code[i] = 23;
      m_dp[i]   = 1'b0;
      m_seen[i] = 1'b0;
    end
  endtask

  // Apply the decoder rules to one stable window.
  task automatic model_window(input logic [7:0] an, input logic [7:0] seg);
    exp_t e;
    int   lows = 0;
    int   which = 0;
    int   code;
    bit   all_seen = 1'b1;
    for (int i = 0; i < 8; i++)
      if (!an[i]) begin lows++; which = i; end
    if (lows == 0) return;
    e.upd = 0; e.idx = 0; e.bad_an = 0; e.bad_pat = 0; e.frame = 0;
    if (lows > 1) begin
      e.bad_an = 1;
    end else begin
      code = ref_decode(seg[6:0]);
      e.upd = 1;
      e.idx = 3'(which);
      e.bad_pat = (code < 0);
      m_code[which] = (code < 0) ? 23 : code;
      m_dp[which]   = ~seg[7];
      m_seen[which] = 1'b1;
      for (int i = 0; i < 8; i++) if (!m_seen[i]) all_seen = 1'b0;
      if (all_seen) begin
        e.frame = 1;
        for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
      end
    end
    e.digits = model_digits();
    e.dp     = model_dp();
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [39:0] act,
                             input logic [39:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one value and hold it for the given number of cycles. A hold shorter
  // than the settle time is a glitch. A value equal to the previous one only
  // extends the current window.
  task automatic applyStimulus(input logic [7:0] an, input logic [7:0] seg,
                               input int hold);
    @(posedge clk);
    #1;
    an_in  = an;
    seg_in = seg;
    if ((an != last_an || seg != last_seg) && hold >= SETTLE)
      model_window(an, seg);
    last_an  = an;
    last_seg = seg;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    checkOutput("pending_events", 40'(exp_q.size()), 40'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    drain();
    @(posedge clk);
    #1;
    an_in = 8'hFF;
    seg_in = 8'hFF;
    reset = 1'b1;
    model_clear();
    last_an = 8'hFF;
    last_seg = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_digits", digits_out, {8{5'd23}});
    checkOutput("reset_dp", 40'(dp_out), 40'h0);
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (digit_update || frame_valid || bad_anode || bad_pattern)) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_pulse: upd=%b bad_an=%b bad_pat=%b frame=%b expected no pulse",
                 digit_update, bad_anode, bad_pattern, frame_valid);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_flags", 40'({digit_update, bad_anode, bad_pattern, frame_valid}),
                    40'({e.upd, e.bad_an, e.bad_pat, e.frame}));
        if (e.upd) checkOutput("update_idx", 40'(update_idx), 40'(e.idx));
        checkOutput("digits_out", digits_out, e.digits);
        checkOutput("dp_out", 40'(dp_out), 40'(e.dp));
      end
    end
  end

  initial begin
    logic [7:0] dps;
    logic [7:0] an, seg;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_digits", digits_out, {8{5'd23}});
    checkOutput("reset_dp", 40'(dp_out), 40'h0);

    // Idle, blank inputs: expect no pulses.
    repeat (100) @(posedge clk);
    #1;
    checkOutput("idle_digits", digits_out, {8{5'd23}});

    // Single digit 0 showing 3 with dp lit.
    applyStimulus(8'hFE, 8'h30, 10);

    // Full scan of codes 0..7 with dp pattern A5.
    dps = 8'hA5;
    for (int i = 0; i < 8; i++)
      applyStimulus(~(8'b1 << i), {~dps[i], pat_of(i)}, 8);
    drain();
    checkOutput("scan_digits", digits_out, 40'h398A418820);
    checkOutput("scan_dp", 40'(dp_out), 40'hA5);

    // Bad anode, then an undecodable pattern on digit 2.
    applyStimulus(8'hFC, 8'h30, LONG_HOLD);
    applyStimulus(8'hFB, 8'h55, LONG_HOLD);

    // Glitch on digit 3, then R aliasing to A on digit 3.
    applyStimulus(8'hF7, 8'h55, 2);
    applyStimulus(8'hFF, 8'hFF, LONG_HOLD);
    applyStimulus(8'hF7, 8'h08, LONG_HOLD);
    drain();
    checkOutput("r_alias_digit3", 40'(digits_out[19:15]), 40'd10);

    // Partial frame, reset, remaining digits, then a full scan.
    do_reset();
    for (int i = 0; i < 6; i++) applyStimulus(~(8'b1 << i), {1'b1, pat_of(i + 8)}, 8);
    do_reset();
    for (int i = 6; i < 8; i++) applyStimulus(~(8'b1 << i), {1'b0, pat_of(i)}, 8);
    for (int i = 0; i < 8; i++) applyStimulus(~(8'b1 << i), {1'b1, pat_of(i + 16)}, 8);

    // Randomized windows with occasional glitches.
    for (int n = 0; n < 80; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 7)      an = ~(8'b1 << $urandom_range(0, 7));
      else if (r < 8) an = 8'hFF;
      else            an = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        seg = {1'($urandom), 7'($urandom)};
      end else begin
        int c = $urandom_range(0, 27);
        if (c >= 26) c++;
        seg = {1'($urandom), pat_of(c)};
      end
      if ($urandom_range(0, 3) == 0)
        applyStimulus(8'($urandom), 8'($urandom), $urandom_range(1, SETTLE - 1));
      if (an == last_an && seg == last_seg) seg[7] = ~seg[7];
      applyStimulus(an, seg, $urandom_range(LONG_HOLD, LONG_HOLD + 4));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sevensegment_scan_decoder.md
Name: sevensegment_scan_decoder

Overview:
- Receive-side counterpart of the 8-digit multiplexed 7-segment driver.
- Samples the active-low anode (an) and cathode (seg) scan lines and reconstructs the 5-bit digit code and decimal point for each of the 8 digits.
- Flags a complete frame once all 8 digits have been seen.
- Used in the board-2 loopback self-test and in simulation scoreboards.
- Decoded codes use the driver's code space: 0-15 hex, 16-22 single segments a-g, 23 blank, 24 H, 25 L, 27 l, 28 r.

Parameters:
- SETTLE_CYCLES, 4: number of consecutive clk cycles {an_in,seg_in} must be unchanged before capture; legal range 1..15.
- CNT_WIDTH, 4: width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous reset, active-high.
- an_in, input, 8: anode lines, active-low; bit i selects digit i.
- seg_in, input, 8: cathode lines, active-low. Bit 7 is dp; bits 6:0 are segments g..a.
- digits_out, output, 40: packed codes; digit i occupies [5i+4:5i].
- dp_out, output, 8: decimal points, active-high (dp_out[i] = ~seg_in[7] at capture of digit i).
- digit_update, output, 1: one-cycle pulse when any digit is captured.
- update_idx, output, 3: index of the captured digit; valid while digit_update is high.
- frame_valid, output, 1: one-cycle pulse when all 8 digits have been captured since the last pulse.
- bad_anode, output, 1: one-cycle pulse when a stable window has more than one anode low.
- bad_pattern, output, 1: one-cycle pulse when a stable window has a segment pattern outside the decode table.

Behaviour:
- Reset (async assert, sync release):
  - Sync registers load an=8'hFF and seg=8'hFF.
  - Settle counter = 0; captured flag = 0; seen mask = 8'h00.
  - digits_out = every field 5'd23; dp_out = 8'h00.
  - All pulse outputs are 0.
- Input path:
  - an_in and seg_in pass through a 2-flop synchronizer (s1 -> s2).
  - s2 is compared to its previous value (s3).
- Settle counter:
  - If s2 != s3: counter <= 0 and captured <= 0.
  - Otherwise the counter increments and saturates at SETTLE_CYCLES-1.
  - The capture condition is: counter == SETTLE_CYCLES-1, captured == 0, and s2 == s3.
  - On that condition, captured <= 1, so there is exactly one capture per stable window.
- Anode classification at the capture condition:
  - All ones: inter-digit blank. No capture, no error.
  - Exactly one zero at bit i: capture digit i.
  - Two or more zeros: bad_anode pulse. No digits_out or dp_out change.
- Segment decode of seg[6:0] (inverse of the driver's table):
  - 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9.
  - 0x08->10, 0x03->11, 0x46->12, 0x21->13, 0x06->14, 0x0E->15.
  - 0x7E->16, 0x7D->17, 0x7B->18, 0x77->19, 0x6F->20, 0x5F->21, 0x3F->22.
  - 0x7F->23, 0x09->24, 0x47->25, 0x4F->27, 0x2F->28.
  - Uppercase R shares 0x08 with A and always decodes to 10; code 26 is never produced.
  - Any other pattern: store 23 and pulse bad_pattern in the same cycle as digit_update.
- Capture of digit i:
  - digits_out field i <= decoded code; dp_out[i] <= ~seg[7].
  - digit_update <= 1; update_idx <= i; mask[i] <= 1.
  - All outputs are registered. They update at the edge following the capture condition, which is SETTLE_CYCLES+3 edges after new values are first presented at an_in/seg_in and then held stable.
- Frame detection:
  - When (mask | (1<<i)) == 8'hFF on a capture, frame_valid pulses with that digit_update and mask <= 0.
  - Re-capturing an already-seen digit only overwrites its field.
- Mid-operation reset clears the mask; a partially collected frame never produces frame_valid.
- A change that lasts fewer than SETTLE_CYCLES cycles (a glitch) is never captured. The next stable window is captured normally.

Test Plan:
- Reset, then idle inputs at an=8'hFF, seg=8'hFF -> digits_out=all 5'd23, dp_out=0, no pulses for 100 cycles.
- an=8'hFE, seg=8'h30 held 10 cycles -> exactly one digit_update with update_idx=0, digits_out[4:0]=3, dp_out[0]=1, no error pulses.
- Drive the driver-format scan for codes 0,1,2,3,4,5,6,7 (digit0..7, dp=8'hA5), 8 cycles per digit -> 8 digit_update pulses; frame_valid coincides with idx=7; digits_out=40'h398A418820; dp_out=8'hA5.
- an=8'hFC held stable -> one bad_anode pulse, no digit_update. an=8'hFB, seg=8'h55 -> digit 2 = 23 and bad_pattern with digit_update.
- SETTLE_CYCLES=4: an=8'hF7 held 2 cycles then 8'hFF -> no capture. seg=8'h08 held stable on digit 3 -> code 10 (R aliases to A).
- Capture digits 0-5, assert reset 1 cycle, then scan digits 6-7 -> no frame_valid. A full 8-digit scan afterward -> one frame_valid.
